r4_line_buffer: RTL and testbench

R4_LINE_BUFFER -- requirements
Module: r4_line_buffer

---
 rtl/r4_line_buffer_pkg.sv | 10 +
 rtl/r4_line_buffer_line_mem.sv | 24 ++
 rtl/r4_line_buffer.sv | 99 +++++++++
 tb/tb_r4_line_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/r4_line_buffer_pkg.sv
// Shared R4 filter constants: pixel width, tap count and counter width.
package r4_line_buffer_pkg;
  localparam int PIX_W = 8;
  localparam int TAPS  = 9;
  localparam int CNT_W = 10;
  localparam int LINES = TAPS - 1;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/r4_line_buffer_line_mem.sv
// One image row of pixel storage with a read-before-write port at a single address.
// Latency: read is combinational and returns the old word; write lands at the clock edge; no backpressure.
module line_mem
  import r4_line_buffer_pkg::*;
#(
  parameter int COLS = 11,
  parameter int AW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [COLS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/r4_line_buffer.sv
// Builds a 9-pixel vertical window from a raster pixel stream using eight chained line memories.
// Latency: 1 cycle from valid_in to outputs; no backpressure, a pixel is accepted on every valid_in.
module r4_line_buffer
  import r4_line_buffer_pkg::*;
#(
  parameter int COLS = 11,
  parameter int ROWS = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [PIX_W-1:0] data_in,
  output logic [PIX_W-1:0] S1,
  output logic [PIX_W-1:0] S2,
  output logic [PIX_W-1:0] S3,
  output logic [PIX_W-1:0] S4,
  output logic [PIX_W-1:0] S5,
  output logic [PIX_W-1:0] S6,
  output logic [PIX_W-1:0] S7,
  output logic [PIX_W-1:0] S8,
  output logic [PIX_W-1:0] S9,
  output logic             valid_o,
  output logic [CNT_W-1:0] col_o,
  output logic             done_o
);

  localparam int AW = $clog2(COLS);

  cnt_t col;
  cnt_t row;
  pix_t rd [LINES];
  pix_t wr [LINES];
  pix_t s_q [TAPS];
  logic wr_en;
  logic last_col;
  logic last_row;

  // Reset wins over a coincident pixel, so the memories do not shift either.
  assign wr_en    = valid_in & ~rst;
  assign last_col = (col == cnt_t'(COLS - 1));
  assign last_row = (row == cnt_t'(ROWS - 1));

  genvar k;
  generate
    for (k = 0; k < LINES; k++) begin : g_line
      if (k == 0) begin : g_head
        assign wr[k] = data_in;
      end else begin : g_tail
        assign wr[k] = rd[k-1];
      end
      line_mem #(.COLS(COLS), .AW(AW)) u_mem (
        .clk   (clk),
        .en    (wr_en),
        .addr  (col[AW-1:0]),
        .wdata (wr[k]),
        .rdata (rd[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      col_o   <= '0;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      for (int j = 0; j < TAPS; j++) s_q[j] <= '0;
    end else begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      if (valid_in) begin
        s_q[TAPS-1] <= data_in;
        // Deepest line holds the oldest row, which lands on the top tap.
        for (int j = 0; j < LINES; j++) s_q[LINES-1-j] <= rd[j];
        col_o   <= col;
        valid_o <= (row >= cnt_t'(LINES));
        done_o  <= last_row & last_col;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign S1 = s_q[0];
  assign S2 = s_q[1];
  assign S3 = s_q[2];
  assign S4 = s_q[3];
  assign S5 = s_q[4];
  assign S6 = s_q[5];
  assign S7 = s_q[6];
  assign S8 = s_q[7];
  assign S9 = s_q[8];

endmodule

// File: tb/tb_r4_line_buffer.sv
// Bench for r4_line_buffer: reference model stores the whole frame and reads columns back by row index.
module tb_r4_line_buffer;
  localparam int COLS = 11;
  localparam int ROWS = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] data_in;
  logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9;
  logic       valid_o;
  logic [9:0] col_o;
  logic       done_o;

  r4_line_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6), .S7(S7), .S8(S8), .S9(S9),
    .valid_o(valid_o), .col_o(col_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  wire [71:0] s_bus = {S1, S2, S3, S4, S5, S6, S7, S8, S9};

  int tests = 0;
  int fails = 0;

  // Reference model: every accepted pixel is stored at its (row, col) image position.
  logic [7:0]  img [ROWS][COLS];
  int          mr, mc;
  logic [71:0] e_bus;
  logic        e_v, e_d;
  logic [9:0]  e_col;
  bit          s_known;

  function automatic logic [7:0] pix(input int r, input int c, input int off);
    return 8'((r * COLS + c + off) % 256);
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0; e_bus = '0; e_v = 1'b0; e_d = 1'b0; e_col = '0; s_known = 1'b1;
  endtask

  task automatic model_pix(input logic [7:0] d);
    img[mr][mc] = d;
    e_v   = (mr >= 8);
    e_d   = (mr == ROWS - 1) && (mc == COLS - 1);
    e_col = 10'(mc);
    if (e_v) begin
      for (int j = 0; j < 9; j++) e_bus[71 - 8*j -: 8] = img[mr - 8 + j][mc];
      s_known = 1'b1;
    end else begin
      s_known = 1'b0;
    end
    mc++;
    if (mc == COLS) begin
      mc = 0;
      mr = (mr == ROWS - 1) ? 0 : mr + 1;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    if (v) model_pix(d);
    else begin e_v = 1'b0; e_d = 1'b0; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; data_in = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (s_bus !== 72'd0 || valid_o !== 1'b0 || done_o !== 1'b0 || col_o !== 10'd0) begin
      fails++;
      $display("FAIL reset: got s=%h v=%b d=%b col=%0d, want all zero", s_bus, valid_o, done_o, col_o);
    end
    rst = 1'b0; valid_in = 1'b0;
    model_reset();
    step(1'b0, 8'h00);
    tests++;
    if (s_bus !== 72'd0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got s=%h v=%b d=%b, want zero", s_bus, valid_o, done_o);
    end
  endtask

  task automatic test_continuous();
    int nv = 0, nd = 0;
    bit first = 1'b1;
    logic [71:0] first_col = {8'd0, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    logic [71:0] last_col  = {8'd32, 8'd43, 8'd54, 8'd65, 8'd76, 8'd87, 8'd98, 8'd109, 8'd120};
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, pix(r, c, 0));
        tests++;
        if (valid_o !== e_v || done_o !== e_d || (e_v && col_o !== e_col) || (s_known && s_bus !== e_bus)) begin
          fails++;
          $display("FAIL continuous r%0d c%0d: got v=%b d=%b col=%0d s=%h, want v=%b d=%b col=%0d s=%h",
                   r, c, valid_o, done_o, col_o, s_bus, e_v, e_d, e_col, e_bus);
        end
        if (valid_o === 1'b1) nv++;
        if (done_o === 1'b1) nd++;
        if (valid_o === 1'b1 && first) begin
          first = 1'b0;
          tests++;
          if (s_bus !== first_col || col_o !== 10'd0) begin
            fails++;
            $display("FAIL first_column: got s=%h col=%0d, want s=%h col=0", s_bus, col_o, first_col);
          end
        end
        if (done_o === 1'b1) begin
          tests++;
          if (s_bus !== last_col || col_o !== 10'd10 || valid_o !== 1'b1) begin
            fails++;
            $display("FAIL last_column: got s=%h col=%0d v=%b, want s=%h col=10 v=1", s_bus, col_o, valid_o, last_col);
          end
        end
      end
    end
    tests++;
    if (nv != (ROWS - 8) * COLS || nd != 1) begin
      fails++;
      $display("FAIL pulse_count: got valid=%0d done=%0d, want valid=%0d done=1", nv, nd, (ROWS - 8) * COLS);
    end
  endtask

  task automatic test_gaps();
    int nv = 0, nd = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, pix(r, c, 0));
        tests++;
        if (valid_o !== e_v || done_o !== e_d || (e_v && col_o !== e_col) || (s_known && s_bus !== e_bus)) begin
          fails++;
          $display("FAIL gaps_pix r%0d c%0d: got v=%b d=%b col=%0d s=%h, want v=%b d=%b col=%0d s=%h",
                   r, c, valid_o, done_o, col_o, s_bus, e_v, e_d, e_col, e_bus);
        end
        if (valid_o === 1'b1) nv++;
        if (done_o === 1'b1) nd++;
        for (int g = 0; g < ((c == 5) ? 5 : 1); g++) begin
          step(1'b0, 8'($urandom));
          tests++;
          if (valid_o !== 1'b0 || done_o !== 1'b0 || (s_known && s_bus !== e_bus)) begin
            fails++;
            $display("FAIL gaps_idle r%0d c%0d: got v=%b d=%b s=%h, want v=0 d=0 s=%h",
                     r, c, valid_o, done_o, s_bus, e_bus);
          end
        end
      end
    end
    tests++;
    if (nv != (ROWS - 8) * COLS || nd != 1) begin
      fails++;
      $display("FAIL gaps_count: got valid=%0d done=%0d, want valid=%0d done=1", nv, nd, (ROWS - 8) * COLS);
    end
  endtask

  task automatic test_mid_reset();
    bit first = 1'b1;
    logic [71:0] first_col = {8'd0, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    for (int i = 0; i < 5 * COLS + 3; i++) step(1'b1, 8'($urandom));
    rst = 1'b1; valid_in = 1'b1; data_in = pix(5, 3, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; valid_in = 1'b0;
    model_reset();
    tests++;
    if (s_bus !== 72'd0 || valid_o !== 1'b0 || done_o !== 1'b0 || col_o !== 10'd0) begin
      fails++;
      $display("FAIL mid_reset: got s=%h v=%b d=%b col=%0d, want all zero", s_bus, valid_o, done_o, col_o);
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, pix(r, c, 0));
        tests++;
        if (valid_o !== e_v || done_o !== e_d || (e_v && col_o !== e_col) || (s_known && s_bus !== e_bus)) begin
          fails++;
          $display("FAIL after_reset r%0d c%0d: got v=%b d=%b col=%0d s=%h, want v=%b d=%b col=%0d s=%h",
                   r, c, valid_o, done_o, col_o, s_bus, e_v, e_d, e_col, e_bus);
        end
        if (valid_o === 1'b1 && first) begin
          first = 1'b0;
          tests++;
          if (r != 8 || c != 0 || s_bus !== first_col) begin
            fails++;
            $display("FAIL reset_first_column: got r%0d c%0d s=%h, want r8 c0 s=%h", r, c, s_bus, first_col);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit first = 1'b1;
    logic [71:0] first_col = {8'd100, 8'd111, 8'd122, 8'd133, 8'd144, 8'd155, 8'd166, 8'd177, 8'd188};
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          step(1'b1, pix(r, c, f * 100));
          tests++;
          if (valid_o !== e_v || done_o !== e_d || (e_v && col_o !== e_col) || (s_known && s_bus !== e_bus)) begin
            fails++;
            $display("FAIL b2b f%0d r%0d c%0d: got v=%b d=%b col=%0d s=%h, want v=%b d=%b col=%0d s=%h",
                     f, r, c, valid_o, done_o, col_o, s_bus, e_v, e_d, e_col, e_bus);
          end
          if (f == 1 && valid_o === 1'b1 && first) begin
            first = 1'b0;
            tests++;
            if (r != 8 || c != 0 || s_bus !== first_col) begin
              fails++;
              $display("FAIL b2b_first_column: got r%0d c%0d s=%h, want r8 c0 s=%h", r, c, s_bus, first_col);
            end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int nv = 0, nd = 0, sent = 0;
    while (sent < 2 * ROWS * COLS) begin
      if ($urandom_range(0, 3) != 0) begin
        step(1'b1, 8'($urandom));
        sent++;
      end else begin
        step(1'b0, 8'($urandom));
      end
      tests++;
      if (valid_o !== e_v || done_o !== e_d || (e_v && col_o !== e_col) || (s_known && s_bus !== e_bus)) begin
        fails++;
        $display("FAIL random n%0d: got v=%b d=%b col=%0d s=%h, want v=%b d=%b col=%0d s=%h",
                 sent, valid_o, done_o, col_o, s_bus, e_v, e_d, e_col, e_bus);
      end
      if (valid_o === 1'b1) nv++;
      if (done_o === 1'b1) nd++;
    end
    tests++;
    if (nv != 2 * (ROWS - 8) * COLS || nd != 2) begin
      fails++;
      $display("FAIL random_count: got valid=%0d done=%0d, want valid=%0d done=2", nv, nd, 2 * (ROWS - 8) * COLS);
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    model_reset();
    test_reset();
    test_continuous();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
